// File: rtl/seg7_scan_capture.sv
// Display readback monitor: watches a multiplexed active-low 7-segment bus and
// recovers the BCD code of each digit, with glitch filtering and frame tracking.
module seg7_scan_capture #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_err,
    output logic                frame_done
);

    localparam logic [3:0] STB    = 4'(STABLE);
    localparam logic [3:0] STB_M1 = 4'(STABLE - 1);

    logic [NDIG-1:0]   an_q;
    logic [6:0]        seg_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              done_q, done_d;

    logic              sel_ok;
    logic              same;
    logic              capture;
    logic [3:0]        code;
    logic              bad;
    logic [NDIG-1:0]   seen_nxt;

    // Returns {unrecognised, code}; blank decodes to F and is not an error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b0, 4'h0};
            7'b1001111: r = {1'b0, 4'h1};
            7'b0010010: r = {1'b0, 4'h2};
            7'b0000110: r = {1'b0, 4'h3};
            7'b1001100: r = {1'b0, 4'h4};
            7'b0100100: r = {1'b0, 4'h5};
            7'b0100000: r = {1'b0, 4'h6};
            7'b0001111: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0000100: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    always_comb begin
        sel_ok      = $onehot(~an_q);
        same        = (an == an_q) && (seg == seg_q);
        {bad, code} = decode(seg_q);

        cnt_d    = cnt_q;
        capture  = 1'b0;
        digits_d = digits_q;
        err_d    = err_q;
        seen_nxt = seen_q;
        seen_d   = seen_q;
        done_d   = 1'b0;

        // Saturating run counter; capture only on the STABLE-1 -> STABLE step.
        if (!sel_ok || !same) begin
            cnt_d = 4'd0;
        end else if (cnt_q != STB) begin
            cnt_d   = cnt_q + 4'd1;
            capture = (cnt_q == STB_M1);
        end

        for (int i = 0; i < NDIG; i++) begin
            if (capture && !an_q[i]) begin
                digits_d[4*i +: 4] = code;
                err_d[i]           = bad;
                seen_nxt[i]        = 1'b1;
            end
        end

        if (capture) begin
            if (&seen_nxt) begin
                seen_d = '0;
                done_d = 1'b1;
            end else begin
                seen_d = seen_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= '1;
            seg_q    <= 7'b1111111;
            cnt_q    <= 4'd0;
            digits_q <= '1;
            err_q    <= '0;
            seen_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            an_q     <= an;
            seg_q    <= seg;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            done_q   <= done_d;
        end
    end

    assign digits     = digits_q;
    assign dig_err    = err_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NDIG=4, STABLE=4): decode table plus
// hand-written sequences for capture timing, filtering, frames and reset.
`timescale 1ns/1ps
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic [15:0] digits;
    logic [3:0]  dig_err;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int fd_count = 0;
    int fd_base;

    typedef struct {
        int         idx;
        logic [6:0] seg;
        logic [3:0] code;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    seg7_scan_capture #(.NDIG(4), .STABLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .digits(digits), .dig_err(dig_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && frame_done) fd_count++;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        vecs[0]  = '{0, 7'b0000001, 4'h0, 1'b0};
        vecs[1]  = '{1, 7'b1001111, 4'h1, 1'b0};
        vecs[2]  = '{2, 7'b0010010, 4'h2, 1'b0};
        vecs[3]  = '{3, 7'b0000110, 4'h3, 1'b0};
        vecs[4]  = '{0, 7'b1001100, 4'h4, 1'b0};
        vecs[5]  = '{1, 7'b0100100, 4'h5, 1'b0};
        vecs[6]  = '{2, 7'b0100000, 4'h6, 1'b0};
        vecs[7]  = '{3, 7'b0001111, 4'h7, 1'b0};
        vecs[8]  = '{0, 7'b0000000, 4'h8, 1'b0};
        vecs[9]  = '{1, 7'b0000100, 4'h9, 1'b0};
        vecs[10] = '{2, 7'b1111111, 4'hF, 1'b0};
        vecs[11] = '{3, 7'b1111110, 4'hE, 1'b1};
        vecs[12] = '{3, 7'b0000110, 4'h3, 1'b0};
        vecs[13] = '{0, 7'b1110111, 4'hE, 1'b1};

        // Reset and idle
        #12;
        check("reset_digits", digits, 16'hFFFF);
        check("reset_err", dig_err, 0);
        check("reset_fd", frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 10);
        check("idle_digits", digits, 16'hFFFF);
        check("idle_fd_count", fd_count, 0);

        // Capture latency: nibble changes on edge 5 exactly
        hold(4'b1110, 7'b0010010, 4);
        check("lat_edge4", digits[3:0], 4'hF);
        step();
        check("lat_edge5", digits[3:0], 4'h2);
        hold(4'b1110, 7'b0010010, 20);
        check("hold_no_change", digits, 16'hFFF2);
        check("hold_no_fd", fd_count, 0);

        // Full scan 7,3,9,0 twice
        for (int rep = 0; rep < 2; rep++) begin
            hold(4'b1110, 7'b0001111, 6);
            hold(4'b1101, 7'b0000110, 6);
            hold(4'b1011, 7'b0000100, 6);
            hold(4'b0111, 7'b0000001, 4);
            check("scan_fd_before", frame_done, 0);
            step();
            check("scan_fd_pulse", frame_done, 1);
            check("scan_digits", digits, 16'h0937);
            step();
            check("scan_fd_after", frame_done, 0);
            check("scan_fd_count", fd_count, rep + 1);
        end

        // Short glitch on digit 1, then blank on digit 2
        hold(4'b1101, 7'b0010010, 3);
        hold(4'b1011, 7'b1111111, 5);
        check("glitch_digits", digits, 16'h0F37);
        check("blank_err", dig_err, 0);

        // Bad pattern then recovery on digit 1
        hold(4'b1101, 7'b0110110, 5);
        check("bad_nibble", digits[7:4], 4'hE);
        check("bad_err", dig_err, 4'b0010);
        hold(4'b1101, 7'b1001111, 5);
        check("fix_nibble", digits[7:4], 4'h1);
        check("fix_err", dig_err, 0);

        // Two an bits low never capture; then reset mid-frame
        hold(4'b1110, 7'b1001100, 5);
        check("d0_four", digits, 16'h0F14);
        fd_base = fd_count;
        hold(4'b1100, 7'b0000000, 10);
        check("multi_low_digits", digits, 16'h0F14);
        check("multi_low_err", dig_err, 0);
        hold(4'b0111, 7'b0000000, 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_digits", digits, 16'hFFFF);
        check("async_rst_fd", frame_done, 0);
        step();
        rst_n = 1'b1;
        hold(4'b0111, 7'b0000000, 6);
        check("post_rst_d3", digits, 16'h8FFF);
        check("post_rst_no_fd", fd_count, fd_base);
        hold(4'b1110, 7'b0000001, 6);
        hold(4'b1101, 7'b1001111, 6);
        check("post_rst_partial", fd_count, fd_base);
        hold(4'b1011, 7'b0010010, 6);
        check("post_rst_frame", fd_count, fd_base + 1);
        check("post_rst_digits", digits, 16'h8210);

        // Decode table
        for (int v = 0; v < 14; v++) begin
            hold(~(4'b0001 << vecs[v].idx), vecs[v].seg, 5);
            check($sformatf("vec%0d_code", v), digits[4*vecs[v].idx +: 4], vecs[v].code);
            check($sformatf("vec%0d_err", v), dig_err[vecs[v].idx], vecs[v].err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reverse of the team's BCD-to-7-segment decoders: observes a multiplexed, active-low 7-segment display bus (segments plus per-digit enables) and recovers the BCD value shown on each digit.
- Used as a display readback and self-check monitor beside the display driver.
- Can also front an external scanned display in the same clock domain.
- Provides glitch filtering, per-digit storage, pattern-error flags and a frame-complete strobe.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE, 4, consecutive matching samples required before capture (2..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- seg  input  7  segment bus, active-low, seg[6]=a … seg[0]=g.
- an  input  NDIG  digit enables, active-low. Exactly one bit low selects a digit.
- digits  output  4*NDIG  recovered codes. digits[4i+3:4i] belongs to digit i.
- dig_err  output  NDIG  per-digit flag: last capture was an unrecognised pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- Single clock domain. One clock, clk. Reset is asynchronous and active-low on rst_n: assertion takes effect immediately, release is synchronous to clk.
- Reset values:
  - digits: every nibble = 4'hF.
  - dig_err = 0; frame_done = 0.
  - Internal sample register = {an all 1, seg = 7'b1111111}.
  - Run counter = 0; seen mask = 0.
- Sampling:
  - {an, seg} is registered every edge into sample register r.
  - The run counter increments (saturating at STABLE) on each edge where the input equals r.
  - The run counter clears to 0 on any mismatch, or when r does not have exactly one an bit low.
- Capture:
  - Fires on the edge where the counter goes from STABLE-1 to STABLE.
  - An input held constant across STABLE+1 consecutive edges updates outputs on the (STABLE+1)-th edge. Example: STABLE=4, input applied before edge 1, digits change at edge 5.
  - Exactly one capture per stable period. Holding longer never re-captures.
  - A change and a return to the same value restarts the count and captures again.
- Decode (active-low, pattern → code):
  - 0000001 → 0
  - 1001111 → 1
  - 0010010 → 2
  - 0000110 → 3
  - 1001100 → 4
  - 0100100 → 5
  - 0100000 → 6
  - 0001111 → 7
  - 0000000 → 8
  - 0000100 → 9
  - 1111111 (blank) → 4'hF
  - Any other pattern → 4'hE with dig_err[i] set.
  - Valid patterns and blank clear dig_err[i].
- Digit selection: the selected digit index i is the position of the single low an bit. Only nibble i and dig_err[i] change on a capture.
- Frame tracking:
  - A capture sets seen[i].
  - If that capture makes seen all ones, frame_done is high for exactly the cycle following that edge, and seen clears to 0 on the same edge.
  - The completing capture is not carried into the next frame.
- Repeated captures of the same digit within a frame overwrite its nibble. They do not advance frame completion.
- an all high, or more than one an bit low: never captures. Counter is held at 0; all stored values are retained.
- Reset mid-count or mid-frame: all state returns to reset values immediately. No capture or frame_done is produced from pre-reset samples.

Test Plan:
- Reset, then idle with an=all 1 → digits=16'hFFFF, dig_err=0, frame_done never asserts.
- an=4'b1110, seg=0010010 held 5 edges (STABLE=4) → digits[3:0]=2 updated at edge 5 exactly. Holding 20 more edges → no further change, no frame_done.
- Scan digits 0..3 showing 7,3,9,0, each held 6 edges → digits=16'h0937, frame_done high for one cycle after the digit-3 capture edge. Repeating the scan → second pulse.
- Digit 1 shown 0010010 for only 3 edges, then seg changes → no capture on digit 1. Then an=4'b1011, seg=1111111 held 5 edges → digit 2 nibble=F, dig_err=0.
- an=4'b1101, seg=0110110 held 5 edges → digits[7:4]=E, dig_err[1]=1. Then seg=1001111 held 5 edges → digits[7:4]=1, dig_err[1]=0.
- an=4'b1100 (two low) held 10 edges → no output change. Then, with 3 digits seen, pulse rst_n low mid-hold → all outputs reset immediately, seen cleared. A full scan is then required before frame_done.
